// File: rtl/md_pkg.sv
// md_pkg: shared constants for the HI/LO multiply-divide sequencer.
//   Opcode encodings seen on aluop_in / md_aluop, FSM state type and
//   small opcode classification helpers.
package md_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 5;

   localparam logic [OP_W-1:0] MD_NOP   = 5'b00000;
   localparam logic [OP_W-1:0] MD_MULT  = 5'b10001;
   localparam logic [OP_W-1:0] MD_MULTU = 5'b10010;
   localparam logic [OP_W-1:0] MD_DIV   = 5'b10011;
   localparam logic [OP_W-1:0] MD_DIVU  = 5'b10100;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   // True for any opcode the md unit can execute
   function automatic logic is_md_op(input logic [OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the multiply family (short latency)
   function automatic logic is_mult_op(input logic [OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: loadable down-counter tracking remaining busy cycles.
//   clk, reset   : clock, async active-high reset (counter -> 0)
//   load         : load load_val this cycle (wins over dec)
//   load_val     : value to load
//   dec          : decrement by one (saturates at zero)
//   zero         : counter currently equals zero
module md_busy_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: sequencer for the HI/LO multiply-divide unit in EX.
//   Latches operands/opcode on issue and holds them for MULT_CYCLES or
//   DIV_CYCLES busy cycles, stalls the pipeline on HI/LO traffic while
//   busy, and gates mthi/mtlo writes into the unit.
//   Inputs : clk, reset (async, active-high), start, aluop_in, da_in,
//            db_in, mt_we, mt_sel, mt_data, mf_req, flush
//   Outputs: stall (comb), busy, done, md_da, md_db, md_aluop,
//            md_wr (comb), md_sel/md_data (passthrough)
module md_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   aluop_in,
   input  logic [DATA_W-1:0] da_in,
   input  logic [DATA_W-1:0] db_in,
   input  logic              mt_we,
   input  logic              mt_sel,
   input  logic [DATA_W-1:0] mt_data,
   input  logic              mf_req,
   input  logic              flush,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] md_da,
   output logic [DATA_W-1:0] md_db,
   output logic [OP_W-1:0]   md_aluop,
   output logic              md_wr,
   output logic              md_sel,
   output logic [DATA_W-1:0] md_data
);

   // Counter is loaded with latency-1 so zero marks the final busy cycle
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   md_state_e         state_q, state_d;
   logic [DATA_W-1:0] da_q, da_d;
   logic [DATA_W-1:0] db_q, db_d;
   logic [OP_W-1:0]   aluop_q, aluop_d;
   logic              cnt_load;
   logic              cnt_dec;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_zero;

   md_busy_cnt #(
      .W (CNT_W)
   ) u_busy_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Next-state, operand capture and counter control
   always_comb begin
      state_d  = state_q;
      da_d     = da_q;
      db_d     = db_q;
      aluop_d  = aluop_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = MULT_LOAD;
      case (state_q)
         ST_IDLE: begin
            // A flushed or unrecognised op never reaches the unit
            if (start && !flush && is_md_op(aluop_in)) begin
               da_d     = da_in;
               db_d     = db_in;
               aluop_d  = aluop_in;
               cnt_load = 1'b1;
               cnt_val  = is_mult_op(aluop_in) ? MULT_LOAD : DIV_LOAD;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Flush is ignored here: an issued op always completes
            if (cnt_zero) begin
               aluop_d = MD_NOP;
               state_d = ST_IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and operand registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         da_q    <= '0;
         db_q    <= '0;
         aluop_q <= MD_NOP;
      end else begin
         state_q <= state_d;
         da_q    <= da_d;
         db_q    <= db_d;
         aluop_q <= aluop_d;
      end
   end

   assign busy     = (state_q == ST_BUSY);
   assign done     = busy & cnt_zero;
   assign stall    = busy & (start | mf_req | mt_we);
   // An md op in the same slot owns EX, so it suppresses the HI/LO write
   assign md_wr    = mt_we & ~busy & ~flush & ~start;
   assign md_sel   = mt_sel;
   assign md_data  = mt_data;
   assign md_da    = da_q;
   assign md_db    = db_q;
   assign md_aluop = aluop_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: self-checking bench for md_ctrl (vector table, directed
// multi-cycle sequences and randomized traffic against a reference model).
module tb_md_ctrl;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   localparam logic [4:0]  OP_MULT  = 5'b10001;
   localparam logic [4:0]  OP_MULTU = 5'b10010;
   localparam logic [4:0]  OP_DIV   = 5'b10011;
   localparam logic [4:0]  OP_DIVU  = 5'b10100;
   localparam logic [4:0]  OP_BAD   = 5'b00111;
   localparam logic [31:0] DB_M3    = 32'hFFFF_FFFD;
   localparam logic [31:0] BEEF     = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  aluop_in;
   logic [31:0] da_in, db_in;
   logic        mt_we, mt_sel;
   logic [31:0] mt_data;
   logic        mf_req, flush;
   logic        stall, busy, done;
   logic [31:0] md_da, md_db;
   logic [4:0]  md_aluop;
   logic        md_wr, md_sel;
   logic [31:0] md_data;

   md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .aluop_in(aluop_in),
      .da_in(da_in), .db_in(db_in), .mt_we(mt_we), .mt_sel(mt_sel),
      .mt_data(mt_data), .mf_req(mf_req), .flush(flush), .stall(stall),
      .busy(busy), .done(done), .md_da(md_da), .md_db(md_db),
      .md_aluop(md_aluop), .md_wr(md_wr), .md_sel(md_sel), .md_data(md_data)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [127:0] pack(input logic s, input logic b, input logic d,
                                         input logic w, input logic sel, input logic [4:0] op,
                                         input logic [31:0] a, input logic [31:0] bb,
                                         input logic [31:0] dat);
      return {22'd0, s, b, d, w, sel, op, a, bb, dat};
   endfunction

   function automatic logic [127:0] dut_out();
      return pack(stall, busy, done, md_wr, md_sel, md_aluop, md_da, md_db, md_data);
   endfunction

   // Reference model: remaining busy cycles plus the captured op
   int          m_rem;
   logic [4:0]  m_op;
   logic [31:0] m_da, m_db;

   task automatic model_reset();
      m_rem = 0; m_op = 5'd0; m_da = 32'd0; m_db = 32'd0;
   endtask

   function automatic logic [127:0] model_out();
      logic b;
      b = (m_rem > 0);
      return pack(b && (start || mf_req || mt_we), b, m_rem == 1,
                  mt_we && !b && !flush && !start, mt_sel, b ? m_op : 5'd0,
                  m_da, m_db, mt_data);
   endfunction

   task automatic model_step();
      if (m_rem > 0) begin
         m_rem--;
      end else if (start && !flush &&
                   (aluop_in == OP_MULT || aluop_in == OP_MULTU ||
                    aluop_in == OP_DIV  || aluop_in == OP_DIVU)) begin
         m_rem = (aluop_in == OP_MULT || aluop_in == OP_MULTU) ? int'(MC) : int'(DC);
         m_op  = aluop_in;
         m_da  = da_in;
         m_db  = db_in;
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; aluop_in = 5'd0; da_in = 32'd0; db_in = 32'd0;
      mt_we = 1'b0; mt_sel = 1'b0; mt_data = 32'd0; mf_req = 1'b0; flush = 1'b0;
   endtask

   // Sample mid-cycle and compare against the model
   task automatic sample(input string name);
      @(negedge clk);
      check(name, dut_out(), model_out());
   endtask

   // Advance the model, then move to just after the next rising edge
   task automatic advance();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic        st;
      logic [4:0]  op;
      logic [31:0] da, db;
      logic        we, sel;
      logic [31:0] dat;
      logic        mf, fl;
      logic        e_stall, e_busy, e_done, e_wr;
      logic [4:0]  e_op;
      logic [31:0] e_da, e_db;
   } vec_t;

   vec_t tv[13];

   logic [31:0] hi, lo;
   logic [4:0]  rops[7];

   initial begin
      //                st    op       da     db     we    sel   dat    mf    fl     stall busy  done  wr    e_op     e_da   e_db
      tv[0]  = '{1'b1, OP_MULT, 32'd7, DB_M3, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,    32'd0, 32'd0};
      tv[1]  = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OP_MULT, 32'd7, DB_M3};
      tv[2]  = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b1, 1'b0, BEEF,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, OP_MULT, 32'd7, DB_M3};
      tv[3]  = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, OP_MULT, 32'd7, DB_M3};
      tv[4]  = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, OP_MULT, 32'd7, DB_M3};
      tv[5]  = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, OP_MULT, 32'd7, DB_M3};
      tv[6]  = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b1, 1'b0, BEEF,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,    32'd7, DB_M3};
      tv[7]  = '{1'b1, OP_MULT, 32'd11,32'd12,1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,    32'd7, DB_M3};
      tv[8]  = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,    32'd7, DB_M3};
      tv[9]  = '{1'b1, OP_BAD,  32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,    32'd7, DB_M3};
      tv[10] = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd7, DB_M3};
      tv[11] = '{1'b1, OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0, BEEF,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,    32'd7, DB_M3};
      tv[12] = '{1'b0, 5'd0,    32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, OP_MULT, 32'd3, 32'd4};

      do_reset();

      // Table: mult timing, mt gating, flush, invalid opcode, start/mt_we clash
      for (int i = 0; i < 13; i++) begin
         start = tv[i].st; aluop_in = tv[i].op; da_in = tv[i].da; db_in = tv[i].db;
         mt_we = tv[i].we; mt_sel = tv[i].sel; mt_data = tv[i].dat;
         mf_req = tv[i].mf; flush = tv[i].fl;
         sample($sformatf("model_tv%0d", i));
         check($sformatf("vec%0d", i), dut_out(),
               pack(tv[i].e_stall, tv[i].e_busy, tv[i].e_done, tv[i].e_wr, tv[i].sel,
                    tv[i].e_op, tv[i].e_da, tv[i].e_db, tv[i].dat));
         advance();
      end
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         sample("drain_tv");
         advance();
      end

      // divu 100/7 with mf_req held: stall through all busy cycles
      start = 1'b1; aluop_in = OP_DIVU; da_in = 32'd100; db_in = 32'd7;
      sample("divu_issue");
      advance();
      idle_inputs();
      mf_req = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         sample("divu_model");
         check($sformatf("divu_c%0d", c), {125'd0, stall, busy, done},
               {125'd0, c <= 10, c <= 10, c == 10});
         if (done) begin
            hi = md_da % md_db;
            lo = md_da / md_db;
            check("divu_hilo", {64'd0, hi, lo}, {64'd0, 32'd2, 32'd14});
         end
         advance();
      end
      idle_inputs();

      // mult then div back-to-back: div waits for done, then runs DC cycles
      start = 1'b1; aluop_in = OP_MULT; da_in = 32'd2; db_in = 32'd3;
      sample("b2b_issue");
      advance();
      aluop_in = OP_DIV; da_in = 32'd50; db_in = 32'd5;
      for (int c = 1; c <= 6; c++) begin
         sample("b2b_model_m");
         check($sformatf("b2b_mult_c%0d", c), {118'd0, stall, busy, done, md_aluop},
               {118'd0, c <= 5, c <= 5, c == 5, (c <= 5) ? OP_MULT : 5'd0});
         advance();
         if (c == 6) start = 1'b0;
      end
      for (int c = 7; c <= 17; c++) begin
         sample("b2b_model_d");
         check($sformatf("b2b_div_c%0d", c), {86'd0, busy, done, md_aluop, md_da},
               {86'd0, c <= 16, c == 16, (c <= 16) ? OP_DIV : 5'd0, 32'd50});
         advance();
      end

      // Reset in busy cycle 4 of a div (by zero): outputs clear at once
      start = 1'b1; aluop_in = OP_DIV; da_in = 32'd9; db_in = 32'd0;
      sample("rst_issue");
      advance();
      idle_inputs();
      for (int c = 1; c <= 4; c++) begin
         sample("rst_model");
         if (c < 4) advance();
      end
      #1 reset = 1'b1;
      #1 check("rst_async", dut_out(), 128'd0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      sample("rst_idle");
      check("rst_idle_busy", {126'd0, busy, done}, 128'd0);
      advance();

      // Randomized traffic against the model
      rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, 5'd0, OP_BAD, 5'b10101};
      for (int i = 0; i < 400; i++) begin
         start    = ($urandom_range(3) == 0);
         aluop_in = rops[$urandom_range(6)];
         da_in    = $urandom;
         db_in    = $urandom;
         mt_we    = ($urandom_range(5) == 0);
         mt_sel   = 1'($urandom_range(1));
         mt_data  = $urandom;
         mf_req   = ($urandom_range(4) == 0);
         flush    = ($urandom_range(7) == 0);
         sample($sformatf("rand%0d", i));
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
